// File: rtl/noc_allocator_rr_if.sv
// noc_allocator_rr_if -- handshake/bus bundle for one switch-output allocator.
//   master : switch side; drives which_port, FLIT_in, VALID_in, busy_in
//   slave  : allocator; drives select, VALID_out, BWDAUX1_out, shift_ctl, timeout_err
interface noc_allocator_rr_if #(
  parameter int N_IN   = 6,
  parameter int FLIT_W = 80,
  parameter int PORT_W = 2
);
  logic [PORT_W-1:0]      which_port;
  logic [N_IN*FLIT_W-1:0] FLIT_in;
  logic [N_IN-1:0]        VALID_in;
  logic                   busy_in;
  logic [N_IN-1:0]        select;
  logic                   VALID_out;
  logic [N_IN-1:0]        BWDAUX1_out;
  logic                   shift_ctl;
  logic                   timeout_err;

  modport master (
    output which_port, FLIT_in, VALID_in, busy_in,
    input  select, VALID_out, BWDAUX1_out, shift_ctl, timeout_err
  );

  modport slave (
    input  which_port, FLIT_in, VALID_in, busy_in,
    output select, VALID_out, BWDAUX1_out, shift_ctl, timeout_err
  );
endinterface

// File: rtl/noc_allocator_rr.sv
// noc_allocator_rr -- per-output allocator for an xpipes-style NoC switch.
// Grants the output to one head/single flit addressed to which_port, holds a
// lock for the owning input until its tail is accepted, and force-releases a
// lock whose owner has been idle for MAX_IDLE cycles (MAX_IDLE=0: no watchdog).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus.slave : which_port/FLIT_in/VALID_in/busy_in in;
//               select/VALID_out/BWDAUX1_out/shift_ctl/timeout_err out
// Build option: define ALLOC_RROBIN_EN for round-robin arbitration; otherwise
// fixed priority (lowest requesting index wins) and no prio register.

// Per-input header decode.
module noc_alloc_lane_dec #(
  parameter int FTYPE_W  = 2,
  parameter int PORT_W   = 2,
  parameter int ENC_HEAD = 0,
  parameter int ENC_TAIL = 2,
  parameter int ENC_SING = 3
)(
  input  logic [FTYPE_W+PORT_W-1:0] hdr_i,
  input  logic                      valid_i,
  input  logic [PORT_W-1:0]         port_i,
  output logic                      req_o,
  output logic                      head_o,
  output logic                      tail_o
);
  logic [FTYPE_W-1:0] ftype;
  logic               is_sing, to_me;

  assign ftype   = hdr_i[FTYPE_W-1:0];
  assign to_me   = hdr_i[FTYPE_W +: PORT_W] == port_i;
  assign is_sing = ftype == FTYPE_W'(ENC_SING);
  assign head_o  = valid_i & (ftype == FTYPE_W'(ENC_HEAD));
  assign tail_o  = valid_i & (ftype == FTYPE_W'(ENC_TAIL));
  assign req_o   = (head_o | (valid_i & is_sing)) & to_me;
endmodule

module noc_allocator_rr #(
  parameter int N_IN     = 6,
  parameter int FLIT_W   = 80,
  parameter int FTYPE_W  = 2,
  parameter int PORT_W   = 2,
  parameter int ENC_HEAD = 0,
  parameter int ENC_PAYL = 1,
  parameter int ENC_TAIL = 2,
  parameter int ENC_SING = 3,
  parameter int MAX_IDLE = 64
)(
  input logic               clk,
  input logic               rst,
  noc_allocator_rr_if.slave bus
);
  localparam logic [N_IN-1:0] LSB   = N_IN'(1);
  localparam int              HDR_W = FTYPE_W + PORT_W;
  // Payload flits need no decode: anything not head/tail/single is body.
  localparam int              unused_enc_payl = ENC_PAYL;

  logic [N_IN-1:0] vld, request, head, tail, owned;
  logic [N_IN-1:0] want, accept, pick, grant_raw, grant;
  logic [N_IN-1:0] lock_q, lock_d;
  logic            avail, wd_fire;
  logic            unused_flit;

  // Only the header field of each flit matters here.
  assign unused_flit = ^bus.FLIT_in;

  // Reset masks all inputs so every output reads zero while rst is high.
  assign vld = bus.VALID_in & {N_IN{~rst}};

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    noc_alloc_lane_dec #(
      .FTYPE_W(FTYPE_W), .PORT_W(PORT_W),
      .ENC_HEAD(ENC_HEAD), .ENC_TAIL(ENC_TAIL), .ENC_SING(ENC_SING)
    ) u_dec (
      .hdr_i  (bus.FLIT_in[i*FLIT_W +: HDR_W]),
      .valid_i(vld[i]),
      .port_i (bus.which_port),
      .req_o  (request[i]),
      .head_o (head[i]),
      .tail_o (tail[i])
    );
  end

  assign owned = lock_q & vld;
  assign avail = ~rst & ~bus.busy_in & ~|lock_q;

`ifdef ALLOC_RROBIN_EN
  logic [N_IN-1:0] prio_q, prio_d, upper;

  // Requesters at or above the pointer take precedence; else wrap to bit 0.
  assign upper  = request & ~(prio_q - LSB);
  assign pick   = (|upper) ? upper : request;
  assign prio_d = (|grant) ? {grant[N_IN-2:0], grant[N_IN-1]} : prio_q;

  always_ff @(posedge clk) begin
    if (rst) prio_q <= LSB;
    else     prio_q <= prio_d;
  end
`else
  assign pick = request;
`endif

  // Isolate lowest set bit of the candidate set.
  assign grant_raw = pick & (~pick + LSB);
  assign grant     = grant_raw & {N_IN{avail}};

  assign want   = (request | lock_q) & vld;
  assign accept = want & (grant | lock_q) & {N_IN{~bus.busy_in}};

  assign bus.select      = grant | owned;
  assign bus.VALID_out   = (|owned) | (~|lock_q & |request);
  assign bus.BWDAUX1_out = want & ~accept;
  assign bus.shift_ctl   = |grant;
  assign bus.timeout_err = wd_fire;

  // Single flits are granted but never lock; watchdog release wins over all.
  assign lock_d = wd_fire ? '0 : ((grant & head) | (lock_q & ~(tail & accept)));

  always_ff @(posedge clk) begin
    if (rst) lock_q <= '0;
    else     lock_q <= lock_d;
  end

  if (MAX_IDLE > 0) begin : g_wd
    localparam int CNT_W = $clog2(MAX_IDLE + 1);
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle;

    // Idle = locked but the owner presents no flit; busy stalls don't count.
    assign idle       = ~rst & (|lock_q) & ~|owned;
    assign wd_fire    = idle & (idle_cnt_q == CNT_W'(MAX_IDLE - 1));
    assign idle_cnt_d = (idle & ~wd_fire) ? idle_cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
      if (rst) idle_cnt_q <= '0;
      else     idle_cnt_q <= idle_cnt_d;
    end
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end
endmodule

// File: tb/tb_noc_allocator_rr.sv
// Directed bench for noc_allocator_rr (N_IN=6, which_port=2, MAX_IDLE=4).
// Expectations follow the arbitration mode selected by ALLOC_RROBIN_EN.
module tb_noc_allocator_rr;
  localparam int N = 6;
  localparam int W = 80;
  localparam logic [1:0] H = 2'd0, P = 2'd1, T = 2'd2, S = 2'd3;
`ifdef ALLOC_RROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] ty [N];
  logic [1:0] pt [N];
  logic [N-1:0] vl;

  noc_allocator_rr_if #(.N_IN(N), .FLIT_W(W), .PORT_W(2)) bus ();

  noc_allocator_rr #(.N_IN(N), .FLIT_W(W), .MAX_IDLE(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(logic [1:0] t, logic [1:0] p);
    logic [W-1:0] f;
    f        = '0;
    f[W-1:4] = {19{4'hC}};
    f[3:2]   = p;
    f[1:0]   = t;
    return f;
  endfunction

  task automatic clr();
    vl = '0;
    for (int i = 0; i < N; i++) begin ty[i] = P; pt[i] = 2'd2; end
  endtask

  task automatic set(int i, logic [1:0] t, logic [1:0] p = 2'd2);
    vl[i] = 1'b1; ty[i] = t; pt[i] = p;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the current vectors, check all outputs, then advance one clock.
  task automatic step(string tag, logic [N-1:0] sel, logic vo, logic [N-1:0] bw,
                      logic sh, logic to);
    for (int i = 0; i < N; i++) bus.FLIT_in[i*W +: W] = mk(ty[i], pt[i]);
    bus.VALID_in = vl;
    #1;
    chk({tag, ".select"},  32'(bus.select),      32'(sel));
    chk({tag, ".valid"},   32'(bus.VALID_out),   32'(vo));
    chk({tag, ".bwd"},     32'(bus.BWDAUX1_out), 32'(bw));
    chk({tag, ".shift"},   32'(bus.shift_ctl),   32'(sh));
    chk({tag, ".timeout"}, 32'(bus.timeout_err), 32'(to));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int own, los, w, l;
    rst = 1'b1;
    bus.busy_in = 1'b0;
    bus.which_port = 2'd2;
    clr();
    for (int i = 0; i < N; i++) set(i, H);
    step("rst", 6'b000000, 0, 6'b000000, 0, 0);
    rst = 1'b0;
    step("first", 6'b000001, 1, 6'b111110, 1, 0);
    // tail from owner; payload on non-owner and head for another port ignored
    clr(); set(0, T); set(3, P); set(5, H, 2'd1);
    step("tail0", 6'b000001, 1, 6'b000000, 0, 0);
    clr();
    step("idle", 6'b000000, 0, 6'b000000, 0, 0);

    // two competing 3-flit packets
    clr(); set(1, H); set(4, H);
    step("b1", 6'b000010, 1, 6'b010000, 1, 0);
    set(1, P); step("b2", 6'b000010, 1, 6'b010000, 0, 0);
    set(1, T); step("b3", 6'b000010, 1, 6'b010000, 0, 0);
    own = RR ? 4 : 1; los = RR ? 1 : 4;
    set(1, H); set(4, H);
    step("b4", 6'(1 << own), 1, 6'(1 << los), 1, 0);
    set(own, P); step("b5", 6'(1 << own), 1, 6'(1 << los), 0, 0);
    set(own, T); step("b6", 6'(1 << own), 1, 6'(1 << los), 0, 0);
    set(1, H); set(4, H);
    step("b7", 6'b000010, 1, 6'b010000, 1, 0);
    clr(); set(1, T);
    step("b8", 6'b000010, 1, 6'b000000, 0, 0);

    // owner tail held off by busy
    clr(); set(2, H);
    step("c1", 6'b000100, 1, 6'b000000, 1, 0);
    bus.busy_in = 1'b1; set(2, T); set(0, H);
    step("c2", 6'b000100, 1, 6'b000101, 0, 0);
    step("c3", 6'b000100, 1, 6'b000101, 0, 0);
    step("c4", 6'b000100, 1, 6'b000101, 0, 0);
    bus.busy_in = 1'b0;
    step("c5", 6'b000100, 1, 6'b000001, 0, 0);
    // busy blocks a fresh grant
    bus.busy_in = 1'b1; clr(); set(0, S);
    step("c6", 6'b000000, 1, 6'b000001, 0, 0);
    bus.busy_in = 1'b0;
    step("c7", 6'b000001, 1, 6'b000000, 1, 0);

    // single flit never locks
    clr(); set(3, S);
    step("d1", 6'b001000, 1, 6'b000000, 1, 0);
    clr(); set(3, P);
    step("d2", 6'b000000, 0, 6'b000000, 0, 0);

    // watchdog: owner 5 goes silent, head on 0 waits
    clr(); set(5, H);
    step("e1", 6'b100000, 1, 6'b000000, 1, 0);
    clr(); set(0, H);
    step("e2", 6'b000000, 0, 6'b000001, 0, 0);
    step("e3", 6'b000000, 0, 6'b000001, 0, 0);
    step("e4", 6'b000000, 0, 6'b000001, 0, 0);
    step("e5", 6'b000000, 0, 6'b000001, 0, 1);
    step("e6", 6'b000001, 1, 6'b000000, 1, 0);
    // tail accepted while competitor heads in: competitor waits a cycle
    set(0, T); set(4, H);
    step("e7", 6'b000001, 1, 6'b010000, 0, 0);
    clr(); set(4, H);
    step("e8", 6'b010000, 1, 6'b000000, 1, 0);
    clr(); set(4, T);
    step("e9", 6'b010000, 1, 6'b000000, 0, 0);

    // reset mid-packet drops the lock
    clr(); set(1, H);
    step("r1", 6'b000010, 1, 6'b000000, 1, 0);
    set(1, P); rst = 1'b1;
    step("r2", 6'b000000, 0, 6'b000000, 0, 0);
    rst = 1'b0; set(2, H);
    step("r3", 6'b000100, 1, 6'b000000, 1, 0);
    clr(); set(2, T);
    step("r4", 6'b000100, 1, 6'b000000, 0, 0);

    // persistent single-flit requests on 0 and 3
    clr(); set(0, S); set(3, S);
    for (int k = 0; k < 4; k++) begin
      w = RR ? ((k % 2 == 0) ? 3 : 0) : 0;
      l = (w == 0) ? 3 : 0;
      step($sformatf("f%0d", k), 6'(1 << w), 1, 6'(1 << l), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_allocator_rr.md
# noc_allocator_rr

Parametrised output-port allocator for the xpipes-style NoC switch. It replaces the fixed-size per-output allocators with one configurable block: N input ports, FLIT_W-bit flits, and PORT_W-bit output IDs. It also adds a lock-idle watchdog that releases an output held by a stalled packet. One instance sits at each switch output, driving that output's crossbar mux select, backpressure and header-shift control.

## Interface
- N_IN, 6: number of input ports (2..16)
- FLIT_W, 80: flit width in bits
- FTYPE_W, 2: flit-type field width, at FLIT bits [FTYPE_W-1:0]
- PORT_W, 2: output-ID field width, at bits [FTYPE_W+PORT_W-1:FTYPE_W]
- ENC_HEAD, 0 / ENC_PAYL, 1 / ENC_TAIL, 2 / ENC_SING, 3: flit-type encodings
- MAX_IDLE, 64: consecutive idle cycles tolerated while the output is locked; 0 disables the watchdog
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- which_port  in  PORT_W  ID of this output port (static)
- FLIT_in  in  N_IN*FLIT_W  input flits; input i occupies bits [i*FLIT_W +: FLIT_W]
- VALID_in  in  N_IN  per-input flit valid
- busy_in  in  1  downstream cannot accept a flit this cycle
- select  out  N_IN  one-hot (or zero) crossbar select
- VALID_out  out  1  output flit valid
- BWDAUX1_out  out  N_IN  per-input not-accept (backpressure)
- shift_ctl  out  1  a head or single flit is granted this cycle; trim one path field
- timeout_err  out  1  one-cycle pulse when the watchdog force-releases the lock

## Operation
- Per input i:
  - request[i] = VALID_in[i] & type∈{HEAD,SING} & (port field == which_port).
  - head[i] and tail[i] are the type decode qualified by VALID_in[i].
- State registers:
  - lock[N_IN]: one-hot or zero; the input currently owning the output.
  - prio[N_IN]: one-hot round-robin pointer.
  - idle_cnt: width clog2(MAX_IDLE+1).
- avail = (lock == 0) & !busy_in.
- grant: at most one bit set, chosen from request, only when avail.
  - Round-robin: first requester scanning upward from the prio index, wrapping past N_IN-1 to 0.
- select = grant | (lock & VALID_in).
- VALID_out = |(lock & VALID_in) | ((lock == 0) & |request).
- Accept and backpressure:
  - want = (request | lock) & VALID_in.
  - accept = want & (grant | lock) & ~busy_in.
  - BWDAUX1_out = want & ~accept.
- shift_ctl = |grant.
- lock_next = (grant & head) | (lock & ~(tail & accept)).
  - A granted SING flit never locks the output.
  - An accepted TAIL on the owning input unlocks it.
- prio_next: rotate-left-by-1 of grant when |grant, otherwise unchanged.
- Watchdog, when MAX_IDLE > 0:
  - While lock != 0 and (lock & VALID_in) == 0, idle_cnt increments; otherwise it clears.
  - When idle_cnt == MAX_IDLE-1 and the increment condition holds:
    - lock_next = 0, idle_cnt clears, timeout_err = 1 for that cycle.
  - busy_in stalls with a valid flit present do not count as idle.

## Timing
- select, VALID_out, BWDAUX1_out and shift_ctl are combinational from the inputs and current state, with zero-cycle latency. The head is forwarded in its grant cycle.
- Lock, priority and watchdog updates take effect the cycle after the triggering edge.
- Reset values:
  - lock = 0, prio = one-hot bit 0, idle_cnt = 0, timeout_err = 0.
  - With all VALID_in low: select = 0, VALID_out = 0, BWDAUX1_out = 0, shift_ctl = 0.
- Reset mid-packet drops the lock immediately. The next packet must start with a head.
- busy_in high blocks new grants. A locked input's flit is still selected but not accepted, and is retried.
- A head whose TAIL is accepted in the same cycle as a competing head arrives: the competitor is granted the next cycle at the earliest.
- A watchdog release and a new request in the same cycle: the new request waits one cycle, because lock is still set that cycle.
- Payload or tail flits on non-owning inputs are never selected.

## Configuration
- ALLOC_RROBIN_EN defined: round-robin arbitration as above, prio register implemented.
- ALLOC_RROBIN_EN undefined: fixed priority, lowest requesting index wins. prio is removed and all other behaviour is unchanged.

## Test plan
- Reset with VALID_in all 1 → all outputs 0 during rst; first cycle after release → grant to input 0, shift_ctl=1.
- Inputs 1 and 4 send heads for this port each cycle, 3-flit packets, busy_in=0, round-robin build → ownership alternates 1,4,1,4. The loser's BWDAUX1_out bit is high on every cycle it loses.
- Owner input 2 sends its tail while busy_in=1 for 3 cycles → lock is held, BWDAUX1_out[2]=1 for 3 cycles, and the release happens the cycle after acceptance.
- SING flit on input 3, nothing locked → one-cycle grant, shift_ctl=1, lock stays 0.
- MAX_IDLE=4, owner input 5 goes invalid after its head → timeout_err pulses in the 4th idle cycle, lock=0 the next cycle, and a pending head on input 0 is granted then.
- Fixed-priority build, requests on inputs 0 and 3 every cycle with SING flits → input 0 always wins and input 3 is starved.
